// File: rtl/cc_decoder_pipe_pkg.sv
// Shared types and default geometry for the cache-controller read-address decoder.
// Default widths describe a 64 B line, 512-set cache on a 32-bit address space.
package cc_pkg;

    localparam int unsigned CC_ADDR_W   = 32;
    localparam int unsigned CC_OFFSET_W = 6;
    localparam int unsigned CC_INDEX_W  = 9;
    localparam int unsigned CC_TAG_W    = CC_ADDR_W - CC_INDEX_W - CC_OFFSET_W;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } cc_state_e;

    typedef struct packed {
        logic [CC_TAG_W-1:0]    tag;
        logic [CC_INDEX_W-1:0]  index;
        logic [CC_OFFSET_W-1:0] offset;
    } cc_req_t;

    function automatic cc_req_t cc_decode(input logic [CC_ADDR_W-1:0] addr);
        cc_req_t req;
        req = cc_req_t'(addr);
        return req;
    endfunction

endpackage

// File: rtl/cc_decoder_pipe_if.sv
// AR request channel from the interconnect plus the decoded-request channel to the hit/miss path.
// The slave modport is the decoder side; master is the interconnect/consumer side.
interface cc_decoder_pipe_if #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned OFFSET_WIDTH = 6,
    parameter int unsigned INDEX_WIDTH  = 9
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    logic [ADDR_WIDTH-1:0]   inct_araddr_i;
    logic                    inct_arvalid_i;
    logic                    inct_arready_o;

    logic                    dec_valid_o;
    logic                    dec_ready_i;
    logic [TAG_WIDTH-1:0]    tag_o;
    logic [INDEX_WIDTH-1:0]  index_o;
    logic [OFFSET_WIDTH-1:0] offset_o;

    modport slave (
        input  inct_araddr_i,
        input  inct_arvalid_i,
        output inct_arready_o,
        output dec_valid_o,
        input  dec_ready_i,
        output tag_o,
        output index_o,
        output offset_o
    );

    modport master (
        output inct_araddr_i,
        output inct_arvalid_i,
        input  inct_arready_o,
        input  dec_valid_o,
        output dec_ready_i,
        input  tag_o,
        input  index_o,
        input  offset_o
    );

endinterface

// File: rtl/cc_decoder_pipe_skid_buf.sv
// Generic 2-entry valid/ready buffer; the head entry is always the oldest and drives o_data.
// Head/tail contents are held when no event occurs, so o_data is stable under back-pressure.
module cc_skid_buf
    import cc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
);

    cc_state_e             r_state;
    cc_state_e             w_next;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    logic w_push;
    logic w_pop;
    logic w_head_we;
    logic w_head_from_tail;
    logic w_tail_we;

    assign o_ready = (r_state != S_FULL);
    assign o_valid = (r_state != S_EMPTY);
    assign o_data  = r_head;

    assign w_push = i_valid & o_ready;
    assign w_pop  = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_head_we        = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_we        = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_next    = S_ONE;
                    w_head_we = 1'b1;
                end
            end
            S_ONE: begin
                if (w_push && !w_pop) begin
                    w_next    = S_FULL;
                    w_tail_we = 1'b1;
                end else if (!w_push && w_pop) begin
                    w_next = S_EMPTY;
                end else if (w_push && w_pop) begin
                    w_head_we = 1'b1;
                end
            end
            S_FULL: begin
                // o_ready is low here, so a push cannot coincide with the pop.
                if (w_pop) begin
                    w_next           = S_ONE;
                    w_head_we        = 1'b1;
                    w_head_from_tail = 1'b1;
                end
            end
            default: begin
                w_next = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_head_we) begin
                r_head <= w_head_from_tail ? r_tail : i_data;
            end
            if (w_tail_we) begin
                r_tail <= i_data;
            end
        end
    end

endmodule

// File: rtl/cc_decoder_pipe.sv
// Registered AR address decoder: gates acceptance on downstream almost-full, buffers two
// requests, slices tag/index/offset from the head entry and counts interconnect stall cycles.
module cc_decoder_pipe
    import cc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = CC_ADDR_W,
    parameter int unsigned OFFSET_WIDTH    = CC_OFFSET_W,
    parameter int unsigned INDEX_WIDTH     = CC_INDEX_W,
    parameter int unsigned NUM_AFULL       = 4,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cc_decoder_pipe_if.slave           bus,
    input  logic [NUM_AFULL-1:0]       afull_i,
    output logic                       hs_pulse_o,
    input  logic                       stall_clr_i,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int unsigned TAG_LSB   = INDEX_WIDTH + OFFSET_WIDTH;

    logic                       w_any_afull;
    logic                       w_buf_ready;
    logic                       w_arready;
    logic                       w_acc;
    logic                       w_stall;
    logic [ADDR_WIDTH-1:0]      w_head;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    assign w_any_afull = |afull_i;

    // rst_n is folded in so ready is low for the whole reset window, not only after an edge.
    assign w_arready = rst_n & ~w_any_afull & w_buf_ready;
    assign w_acc     = bus.inct_arvalid_i & w_arready;
    assign w_stall   = bus.inct_arvalid_i & ~w_arready;

    assign bus.inct_arready_o = w_arready;
    assign hs_pulse_o         = w_acc;

    cc_skid_buf #(
        .DATA_WIDTH (ADDR_WIDTH)
    ) u_skid_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_acc),
        .o_ready (w_buf_ready),
        .i_data  (bus.inct_araddr_i),
        .o_valid (bus.dec_valid_o),
        .i_ready (bus.dec_ready_i),
        .o_data  (w_head)
    );

    assign bus.tag_o    = w_head[ADDR_WIDTH-1:TAG_LSB];
    assign bus.index_o  = w_head[TAG_LSB-1:OFFSET_WIDTH];
    assign bus.offset_o = w_head[OFFSET_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_clr_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_cc_decoder_pipe.sv
// Directed and random stimulus for cc_decoder_pipe against a queue-based reference model.
module tb_cc_decoder_pipe;
    import cc_pkg::*;

    localparam int unsigned SCW = 4;

    logic            clk;
    logic            rst_n;
    logic [3:0]      afull;
    logic            hs_pulse;
    logic            stall_clr;
    logic [SCW-1:0]  stall_cnt;

    cc_decoder_pipe_if #(
        .ADDR_WIDTH   (32),
        .OFFSET_WIDTH (6),
        .INDEX_WIDTH  (9)
    ) bus ();

    cc_decoder_pipe #(
        .ADDR_WIDTH      (32),
        .OFFSET_WIDTH    (6),
        .INDEX_WIDTH     (9),
        .NUM_AFULL       (4),
        .STALL_CNT_WIDTH (SCW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .afull_i     (afull),
        .hs_pulse_o  (hs_pulse),
        .stall_clr_i (stall_clr),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] q[$];
    int unsigned m_stall = 0;
    logic        last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare at the falling edge against the model, then advance the model on the rising edge.
    task automatic tick();
        logic    exp_rdy;
        logic    exp_hs;
        logic    exp_v;
        cc_req_t h;
        @(negedge clk);
        exp_rdy = (afull == 4'd0) && (q.size() < 2);
        exp_hs  = bus.inct_arvalid_i && exp_rdy;
        exp_v   = (q.size() != 0);
        chk("arready",   {31'd0, bus.inct_arready_o}, {31'd0, exp_rdy});
        chk("hs_pulse",  {31'd0, hs_pulse},           {31'd0, exp_hs});
        chk("dec_valid", {31'd0, bus.dec_valid_o},    {31'd0, exp_v});
        chk("stall_cnt", {28'd0, stall_cnt},          m_stall);
        if (exp_v) begin
            h = cc_decode(q[0]);
            chk("tag",    {15'd0, bus.tag_o},    {15'd0, h.tag});
            chk("index",  {23'd0, bus.index_o},  {23'd0, h.index});
            chk("offset", {26'd0, bus.offset_o}, {26'd0, h.offset});
        end
        @(posedge clk);
        last_acc = exp_hs;
        if (exp_v && bus.dec_ready_i) void'(q.pop_front());
        if (exp_hs) q.push_back(bus.inct_araddr_i);
        if (stall_clr) m_stall = 0;
        else if (bus.inct_arvalid_i && !exp_rdy && m_stall != (1 << SCW) - 1) m_stall++;
        #1;
    endtask

    task automatic send(input logic [31:0] addr);
        bus.inct_araddr_i  = addr;
        bus.inct_arvalid_i = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
        bus.inct_arvalid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_valid"},  {31'd0, bus.dec_valid_o},    32'd0);
        chk({pfx, "_arrdy"},  {31'd0, bus.inct_arready_o}, 32'd0);
        chk({pfx, "_hs"},     {31'd0, hs_pulse},           32'd0);
        chk({pfx, "_tag"},    {15'd0, bus.tag_o},          32'd0);
        chk({pfx, "_index"},  {23'd0, bus.index_o},        32'd0);
        chk({pfx, "_offset"}, {26'd0, bus.offset_o},       32'd0);
        chk({pfx, "_stall"},  {28'd0, stall_cnt},          32'd0);
    endtask

    initial begin
        rst_n              = 1'b0;
        afull              = 4'd0;
        stall_clr          = 1'b0;
        bus.inct_araddr_i  = 32'h1234_5678;
        bus.inct_arvalid_i = 1'b1;
        bus.dec_ready_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.inct_arvalid_i = 1'b0;
        @(posedge clk);
        #1;

        // Single request into an empty buffer.
        bus.inct_araddr_i  = 32'h1234_5678;
        bus.inct_arvalid_i = 1'b1;
        #1;
        chk("t1_hs", {31'd0, hs_pulse}, 32'd1);
        tick();
        bus.inct_arvalid_i = 1'b0;
        chk("t1_valid",  {31'd0, bus.dec_valid_o}, 32'd1);
        chk("t1_tag",    {15'd0, bus.tag_o},       32'h0_2468);
        chk("t1_index",  {23'd0, bus.index_o},     32'h159);
        chk("t1_offset", {26'd0, bus.offset_o},    32'h38);
        tick();
        bus.dec_ready_i = 1'b1;
        tick();

        // Back-to-back streaming, one per cycle.
        for (int i = 0; i < 8; i++) begin
            send(32'hA000_0000 + (i * 32'h0001_0041));
            chk("stream_acc_1cyc", {31'd0, last_acc}, 32'd1);
        end
        repeat (2) tick();

        // Fill and drain: third request waits for space.
        bus.dec_ready_i = 1'b0;
        send(32'h0000_AAC0);
        send(32'h0000_BBC1);
        chk("full_arrdy", {31'd0, bus.inct_arready_o}, 32'd0);
        bus.inct_araddr_i  = 32'h0000_CCC2;
        bus.inct_arvalid_i = 1'b1;
        repeat (3) tick();
        bus.dec_ready_i = 1'b1;
        send(32'h0000_CCC2);
        repeat (3) tick();

        // Almost-full gating while a buffered entry still drains.
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        bus.dec_ready_i = 1'b0;
        send(32'h5555_0001);
        afull = 4'b0100;
        bus.dec_ready_i = 1'b1;
        bus.inct_araddr_i  = 32'h6666_0002;
        bus.inct_arvalid_i = 1'b1;
        repeat (5) tick();
        chk("afull_stall5", {28'd0, stall_cnt}, 32'd5);
        chk("afull_drained", {31'd0, bus.dec_valid_o}, 32'd0);

        // Saturation, then clear during an ongoing stall.
        repeat (20) tick();
        chk("sat_15", {28'd0, stall_cnt}, 32'd15);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("clr_0", {28'd0, stall_cnt}, 32'd0);
        tick();
        chk("resume_1", {28'd0, stall_cnt}, 32'd1);
        afull = 4'd0;
        bus.inct_arvalid_i = 1'b0;
        repeat (2) tick();

        // Asynchronous reset with the buffer full.
        bus.dec_ready_i = 1'b0;
        send(32'h1111_1111);
        send(32'h2222_2222);
        bus.inct_araddr_i  = 32'h3333_3333;
        bus.inct_arvalid_i = 1'b1;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        q.delete();
        m_stall = 0;
        bus.inct_arvalid_i = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("arst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'hDEAD_BEEF);
        chk("post_rst_tag",    {15'd0, bus.tag_o},    32'h1_BD5B);
        chk("post_rst_index",  {23'd0, bus.index_o},  32'hFB);
        chk("post_rst_offset", {26'd0, bus.offset_o}, 32'h2F);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.inct_araddr_i  = $urandom;
            bus.inct_arvalid_i = ($urandom_range(0, 3) != 0);
            bus.dec_ready_i    = ($urandom_range(0, 2) != 0);
            afull              = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            stall_clr          = ($urandom_range(0, 30) == 0);
            tick();
        end
        bus.inct_arvalid_i = 1'b0;
        afull              = 4'd0;
        stall_clr          = 1'b0;
        bus.dec_ready_i    = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
